// File: rtl/dm_axi_master.sv
// CPU data-memory port to single-outstanding, single-beat AXI4 master.
// Optional posted writes: define DM_POSTED_WRITE_EN to retire writes on AW/W and track B with a pending flag.
module dm_axi_master #(
  parameter int unsigned          ID_W   = 4,
  parameter logic [ID_W-1:0]      M_ID   = ID_W'(1),
  parameter int unsigned          ADDR_W = 32,
  parameter int unsigned          DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // CPU data-memory side
  input  logic              DM_WEB,
  input  logic              DM_write,
  input  logic [3:0]        DM_BWEB,
  input  logic [ADDR_W-1:0] DM_addr,
  input  logic [DATA_W-1:0] DM_DI,
  output logic [DATA_W-1:0] DM_DO,
  output logic              DM_stall,
  output logic              dm_bus_err,
  // read address channel
  output logic [ID_W-1:0]   ARID,
  output logic [ADDR_W-1:0] ARADDR,
  output logic [7:0]        ARLEN,
  output logic [2:0]        ARSIZE,
  output logic [1:0]        ARBURST,
  output logic              ARVALID,
  input  logic              ARREADY,
  // read data channel
  input  logic [ID_W-1:0]   RID,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RLAST,
  input  logic              RVALID,
  output logic              RREADY,
  // write address channel
  output logic [ID_W-1:0]   AWID,
  output logic [ADDR_W-1:0] AWADDR,
  output logic [7:0]        AWLEN,
  output logic [2:0]        AWSIZE,
  output logic [1:0]        AWBURST,
  output logic              AWVALID,
  input  logic              AWREADY,
  // write data channel
  output logic [DATA_W-1:0] WDATA,
  output logic [3:0]        WSTRB,
  output logic              WLAST,
  output logic              WVALID,
  input  logic              WREADY,
  // write response channel
  input  logic [ID_W-1:0]   BID,
  input  logic [1:0]        BRESP,
  input  logic              BVALID,
  output logic              BREADY,
  // FSM state for observation
  output logic [2:0]        dbg_state_o
);

  // Handshake rule on every AXI channel: a transfer happens on a rising clk edge
  // where VALID and READY are both high; once raised, VALID and its payload stay
  // stable until that transfer, and VALID never waits on READY.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_A  = 3'd1,
    S_RD_D  = 3'd2,
    S_WR_AW = 3'd3,
    S_WR_B  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [3:0]          strb_q, strb_d;
  logic                aw_vld_q, aw_vld_d;
  logic                w_vld_q, w_vld_d;
  logic [DATA_W-1:0]   do_q, do_d;
  logic                err_q, err_d;
  logic                pend_q, pend_d;
  logic                req;
  logic                accept;

  assign req = DM_WEB | DM_write;

`ifdef DM_POSTED_WRITE_EN
  // An unacknowledged posted write blocks the next access until its B arrives.
  assign accept = (state_q == S_IDLE) && req && !pend_q;
`else
  assign accept = (state_q == S_IDLE) && req;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    aw_vld_d = aw_vld_q;
    w_vld_d  = w_vld_q;
    do_d     = do_q;
    err_d    = err_q;
    pend_d   = pend_q;
    ARVALID  = 1'b0;
    RREADY   = 1'b0;
    BREADY   = 1'b0;

`ifdef DM_POSTED_WRITE_EN
    BREADY = pend_q;
    if (pend_q && BVALID) begin
      pend_d = 1'b0;
      if (BRESP != 2'b00) err_d = 1'b1;
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = DM_addr;
          data_d = DM_DI;
          strb_d = DM_BWEB;
          if (DM_write) begin
            state_d  = S_WR_AW;
            aw_vld_d = 1'b1;
            w_vld_d  = 1'b1;
          end else begin
            state_d = S_RD_A;
          end
        end
      end
      S_RD_A: begin
        ARVALID = 1'b1;
        if (ARREADY) state_d = S_RD_D;
      end
      S_RD_D: begin
        RREADY = 1'b1;
        if (RVALID) begin
          do_d    = (RRESP == 2'b00) ? RDATA : '0;
          if (RRESP != 2'b00) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_WR_AW: begin
        // AW and W complete independently; leave only once both are done.
        aw_vld_d = aw_vld_q && !AWREADY;
        w_vld_d  = w_vld_q && !WREADY;
        if (!aw_vld_d && !w_vld_d) begin
`ifdef DM_POSTED_WRITE_EN
          state_d = S_DONE;
          pend_d  = 1'b1;
`else
          state_d = S_WR_B;
`endif
        end
      end
      S_WR_B: begin
        BREADY = 1'b1;
        if (BVALID) begin
          if (BRESP != 2'b00) err_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      aw_vld_q <= 1'b0;
      w_vld_q  <= 1'b0;
      do_q     <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      strb_q   <= strb_d;
      aw_vld_q <= aw_vld_d;
      w_vld_q  <= w_vld_d;
      do_q     <= do_d;
      err_q    <= err_d;
      pend_q   <= pend_d;
    end
  end

  // Stall is forced low during reset so a held request cannot freeze the pipeline.
  assign DM_stall = rst && (((state_q == S_IDLE) && req) ||
                            ((state_q != S_IDLE) && (state_q != S_DONE)));

  assign DM_DO       = do_q;
  assign dm_bus_err  = err_q;
  assign dbg_state_o = state_q;

  assign ARID    = M_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

  assign AWID    = M_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign AWVALID = aw_vld_q;

  assign WDATA   = data_q;
  assign WSTRB   = strb_q;
  assign WLAST   = 1'b1;
  assign WVALID  = w_vld_q;

  // Response IDs and RLAST carry no information for a single-outstanding, single-beat master.
  logic unused_in;
  assign unused_in = ^{RID, BID, RLAST};

endmodule

// File: tb/tb_dm_axi_master.sv
// Directed testbench for dm_axi_master: reads, writes with backpressure, back-to-back loads,
// bus errors, mid-transaction reset and (with DM_POSTED_WRITE_EN) posted writes.
module tb_dm_axi_master;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_RD_A = 3'd1, ST_RD_D = 3'd2,
                         ST_WR_AW = 3'd3, ST_WR_B = 3'd4, ST_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        DM_WEB = 1'b0, DM_write = 1'b0;
  logic [3:0]  DM_BWEB = '0;
  logic [31:0] DM_addr = '0, DM_DI = '0;
  logic [31:0] DM_DO;
  logic        DM_stall, dm_bus_err;
  logic [3:0]  ARID, AWID;
  logic [31:0] ARADDR, AWADDR, WDATA;
  logic [7:0]  ARLEN, AWLEN;
  logic [2:0]  ARSIZE, AWSIZE, dbg_state;
  logic [1:0]  ARBURST, AWBURST;
  logic        ARVALID, RREADY, AWVALID, WVALID, WLAST, BREADY;
  logic [3:0]  WSTRB;
  logic        ARREADY = 1'b0, RVALID = 1'b0, RLAST = 1'b1, AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0;
  logic [3:0]  RID = 4'd1, BID = 4'd1;
  logic [31:0] RDATA = '0;
  logic [1:0]  RRESP = '0, BRESP = '0;

  int checks = 0;
  int errors = 0;
  int ar_hs  = 0;

  dm_axi_master dut (
    .clk(clk), .rst(rst),
    .DM_WEB(DM_WEB), .DM_write(DM_write), .DM_BWEB(DM_BWEB), .DM_addr(DM_addr), .DM_DI(DM_DI),
    .DM_DO(DM_DO), .DM_stall(DM_stall), .dm_bus_err(dm_bus_err),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .dbg_state_o(dbg_state)
  );

  // Clock and handshake monitor
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && ARVALID && ARREADY) ar_hs++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1);
  end

  // ---------------- driver tasks (stimulus only) ----------------
  task automatic idle(input int n);
    DM_WEB = 1'b0; DM_write = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Zero-wait read; returns in the DONE cycle with DM_WEB still high.
  task automatic drive_read(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                            output int stall_cyc, output logic [31:0] do_val,
                            output logic [31:0] araddr_seen);
    bit done = 0;
    stall_cyc = 0; do_val = 'x; araddr_seen = 'x;
    DM_WEB = 1'b1; DM_write = 1'b0; DM_addr = a;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!DM_stall) begin do_val = DM_DO; done = 1; break; end
      stall_cyc++;
      if (ARVALID) araddr_seen = ARADDR;
      ARREADY = ARVALID;
      RVALID = RREADY; RDATA = d; RRESP = resp;
      @(negedge clk); #1;
    end
    ARREADY = 1'b0; RVALID = 1'b0; RRESP = 2'b00;
    if (!done) stall_cyc = -1;
  endtask

  // Zero-wait write; lowers the request once the stall releases and finishes any outstanding B.
  task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [1:0] resp, output int stall_cyc,
                             output logic [31:0] wdata_seen, output logic [3:0] wstrb_seen,
                             output logic [31:0] awaddr_seen);
    bit done = 0;
    stall_cyc = 0; wdata_seen = 'x; wstrb_seen = 'x; awaddr_seen = 'x;
    DM_write = 1'b1; DM_WEB = 1'b0; DM_addr = a; DM_DI = d; DM_BWEB = s;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (!DM_stall) DM_write = 1'b0;
      if (!DM_stall && !BREADY) begin done = 1; break; end
      if (DM_stall) stall_cyc++;
      if (AWVALID) awaddr_seen = AWADDR;
      if (WVALID) begin wdata_seen = WDATA; wstrb_seen = WSTRB; end
      AWREADY = AWVALID; WREADY = WVALID;
      BVALID = BREADY; BRESP = resp;
      @(negedge clk); #1;
    end
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    if (!done) stall_cyc = -1;
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    DM_WEB = 1'b1; DM_addr = 32'h0000_0100;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0) begin errors++;
      $display("FAIL reset_handshakes: got %b expected 00000", {ARVALID, RREADY, AWVALID, WVALID, BREADY}); end
    checks++; if (DM_stall !== 1'b0) begin errors++;
      $display("FAIL reset_stall: got %b expected 0", DM_stall); end
    checks++; if (DM_DO !== 32'h0) begin errors++;
      $display("FAIL reset_dm_do: got %h expected 00000000", DM_DO); end
    checks++; if (dm_bus_err !== 1'b0) begin errors++;
      $display("FAIL reset_bus_err: got %b expected 0", dm_bus_err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    checks++; if ({ARID, AWID, ARLEN, AWLEN, ARSIZE, AWSIZE, ARBURST, AWBURST, WLAST} !==
                  {4'd1, 4'd1, 8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1}) begin errors++;
      $display("FAIL const_outputs: got %h expected %h",
               {ARID, AWID, ARLEN, AWLEN, ARSIZE, AWSIZE, ARBURST, AWBURST, WLAST},
               {4'd1, 4'd1, 8'd0, 8'd0, 3'b010, 3'b010, 2'b01, 2'b01, 1'b1}); end
    DM_WEB = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_read();
    int st; logic [31:0] dov, ara;
    drive_read(32'h0001_0004, 32'hDEAD_BEEF, 2'b00, st, dov, ara);
    checks++; if (ara !== 32'h0001_0004) begin errors++;
      $display("FAIL read_araddr: got %h expected 00010004", ara); end
    checks++; if (st !== 3) begin errors++;
      $display("FAIL read_stall_cycles: got %0d expected 3", st); end
    checks++; if (dov !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL read_dm_do: got %h expected deadbeef", dov); end
    idle(2);
    checks++; if ({DM_stall, dbg_state} !== {1'b0, ST_IDLE} || DM_DO !== 32'hDEAD_BEEF) begin errors++;
      $display("FAIL read_hold: got stall=%b state=%0d do=%h expected 0/0/deadbeef", DM_stall, dbg_state, DM_DO); end
  endtask

  task automatic test_write_backpressure();
    // Read and write requested together: the write must win.
    DM_write = 1'b1; DM_WEB = 1'b1; DM_addr = 32'h2000_0040; DM_DI = 32'h1234_5678; DM_BWEB = 4'b0011;
    #1;
    checks++; if ({DM_stall, AWVALID, WVALID} !== 3'b100) begin errors++;
      $display("FAIL wr_c0: got %b expected 100", {DM_stall, AWVALID, WVALID}); end
    @(negedge clk); #1;
    checks++; if ({dbg_state, AWVALID, WVALID, ARVALID} !== {ST_WR_AW, 3'b110}) begin errors++;
      $display("FAIL wr_entry: got %b expected %b", {dbg_state, AWVALID, WVALID, ARVALID}, {ST_WR_AW, 3'b110}); end
    checks++; if ({AWADDR, WDATA, WSTRB} !== {32'h2000_0040, 32'h1234_5678, 4'b0011}) begin errors++;
      $display("FAIL wr_payload: got %h expected %h", {AWADDR, WDATA, WSTRB}, {32'h2000_0040, 32'h1234_5678, 4'b0011}); end
    WREADY = 1'b1;
    @(negedge clk); #1;
    WREADY = 1'b0;
    checks++; if ({AWVALID, WVALID, DM_stall} !== 3'b101) begin errors++;
      $display("FAIL wr_w_drop: got %b expected 101", {AWVALID, WVALID, DM_stall}); end
    @(negedge clk); #1;
    checks++; if ({AWVALID, WVALID} !== 2'b10) begin errors++;
      $display("FAIL wr_aw_hold: got %b expected 10", {AWVALID, WVALID}); end
    AWREADY = 1'b1;
    @(negedge clk); #1;
    AWREADY = 1'b0;
    checks++; if ({dbg_state, AWVALID, WVALID, BREADY, DM_stall} !== {ST_WR_B, 4'b0011}) begin errors++;
      $display("FAIL wr_to_b: got %b expected %b", {dbg_state, AWVALID, WVALID, BREADY, DM_stall}, {ST_WR_B, 4'b0011}); end
    @(negedge clk); #1;
    checks++; if (DM_stall !== 1'b1) begin errors++;
      $display("FAIL wr_wait_b: got %b expected 1", DM_stall); end
    BVALID = 1'b1; BRESP = 2'b00;
    @(negedge clk); #1;
    BVALID = 1'b0;
    checks++; if ({dbg_state, DM_stall} !== {ST_DONE, 1'b0}) begin errors++;
      $display("FAIL wr_done: got %b expected %b", {dbg_state, DM_stall}, {ST_DONE, 1'b0}); end
    idle(1);
  endtask

  task automatic test_write();
    int st; logic [31:0] wd, aw; logic [3:0] ws; int exp_st;
`ifdef DM_POSTED_WRITE_EN
    exp_st = 2;
`else
    exp_st = 3;
`endif
    drive_write(32'h0000_0080, 32'hA5A5_0F0F, 4'b1100, 2'b00, st, wd, ws, aw);
    checks++; if (st !== exp_st) begin errors++;
      $display("FAIL write_stall_cycles: got %0d expected %0d", st, exp_st); end
    checks++; if ({aw, wd, ws} !== {32'h0000_0080, 32'hA5A5_0F0F, 4'b1100}) begin errors++;
      $display("FAIL write_payload: got %h expected %h", {aw, wd, ws}, {32'h0000_0080, 32'hA5A5_0F0F, 4'b1100}); end
    idle(1);
    checks++; if ({dm_bus_err, dbg_state} !== {1'b0, ST_IDLE}) begin errors++;
      $display("FAIL write_end: got %b expected %b", {dm_bus_err, dbg_state}, {1'b0, ST_IDLE}); end
  endtask

  task automatic test_back_to_back();
    int st; logic [31:0] dov, ara; int ar0;
    ar0 = ar_hs;
    drive_read(32'h0000_0010, 32'h1111_1111, 2'b00, st, dov, ara);
    checks++; if ({dbg_state, ARVALID} !== {ST_DONE, 1'b0} || dov !== 32'h1111_1111) begin errors++;
      $display("FAIL b2b_first: got state=%0d arvalid=%b do=%h expected 5/0/11111111", dbg_state, ARVALID, dov); end
    @(negedge clk); #1;
    checks++; if ({dbg_state, DM_stall, ARVALID} !== {ST_IDLE, 2'b10}) begin errors++;
      $display("FAIL b2b_stale_ignored: got %b expected %b", {dbg_state, DM_stall, ARVALID}, {ST_IDLE, 2'b10}); end
    drive_read(32'h0000_0010, 32'h2222_2222, 2'b00, st, dov, ara);
    checks++; if (st !== 3 || ara !== 32'h0000_0010 || dov !== 32'h2222_2222) begin errors++;
      $display("FAIL b2b_second: got st=%0d ar=%h do=%h expected 3/00000010/22222222", st, ara, dov); end
    checks++; if (ar_hs - ar0 !== 2) begin errors++;
      $display("FAIL b2b_ar_count: got %0d expected 2", ar_hs - ar0); end
    idle(1);
  endtask

  task automatic test_read_error();
    int st; logic [31:0] dov, ara;
    drive_read(32'h0000_0020, 32'hCAFE_F00D, 2'b10, st, dov, ara);
    checks++; if (dov !== 32'h0) begin errors++;
      $display("FAIL rerr_dm_do: got %h expected 00000000", dov); end
    idle(1);
    checks++; if (dm_bus_err !== 1'b1) begin errors++;
      $display("FAIL rerr_flag: got %b expected 1", dm_bus_err); end
    drive_read(32'h0000_0024, 32'h0BAD_C0DE, 2'b00, st, dov, ara);
    idle(2);
    checks++; if ({dm_bus_err, DM_DO} !== {1'b1, 32'h0BAD_C0DE}) begin errors++;
      $display("FAIL rerr_sticky: got %h expected %h", {dm_bus_err, DM_DO}, {1'b1, 32'h0BAD_C0DE}); end
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] dov, ara;
    DM_WEB = 1'b1; DM_addr = 32'h0000_0030;
    #1;
    @(negedge clk); #1;
    ARREADY = 1'b1;
    @(negedge clk); #1;
    ARREADY = 1'b0;
    checks++; if ({dbg_state, RREADY, DM_stall} !== {ST_RD_D, 2'b11}) begin errors++;
      $display("FAIL rstmid_in_rd_d: got %b expected %b", {dbg_state, RREADY, DM_stall}, {ST_RD_D, 2'b11}); end
    rst = 1'b0;
    #1;
    checks++; if ({ARVALID, RREADY, DM_stall} !== 3'b000) begin errors++;
      $display("FAIL rstmid_outputs: got %b expected 000", {ARVALID, RREADY, DM_stall}); end
    checks++; if ({dbg_state, DM_DO, dm_bus_err} !== {ST_IDLE, 32'h0, 1'b0}) begin errors++;
      $display("FAIL rstmid_regs: got %h expected %h", {dbg_state, DM_DO, dm_bus_err}, {ST_IDLE, 32'h0, 1'b0}); end
    DM_WEB = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    drive_read(32'h0000_0034, 32'h5555_AAAA, 2'b00, st, dov, ara);
    checks++; if (st !== 3 || ara !== 32'h0000_0034 || dov !== 32'h5555_AAAA) begin errors++;
      $display("FAIL rstmid_next_read: got st=%0d ar=%h do=%h expected 3/00000034/5555aaaa", st, ara, dov); end
    idle(1);
  endtask

  task automatic test_write_error();
    int st; logic [31:0] wd, aw; logic [3:0] ws;
    checks++; if (dm_bus_err !== 1'b0) begin errors++;
      $display("FAIL werr_pre: got %b expected 0", dm_bus_err); end
    drive_write(32'h0000_0040, 32'h0000_00FF, 4'b1111, 2'b11, st, wd, ws, aw);
    idle(1);
    checks++; if (dm_bus_err !== 1'b1) begin errors++;
      $display("FAIL werr_flag: got %b expected 1", dm_bus_err); end
  endtask

`ifdef DM_POSTED_WRITE_EN
  task automatic test_posted();
    DM_write = 1'b1; DM_addr = 32'h0000_0050; DM_DI = 32'h0102_0304; DM_BWEB = 4'b1111;
    #1;
    checks++; if (DM_stall !== 1'b1) begin errors++;
      $display("FAIL post_c0_stall: got %b expected 1", DM_stall); end
    @(negedge clk); #1;
    checks++; if ({AWVALID, WVALID, DM_stall} !== 3'b111) begin errors++;
      $display("FAIL post_c1: got %b expected 111", {AWVALID, WVALID, DM_stall}); end
    AWREADY = 1'b1; WREADY = 1'b1;
    @(negedge clk); #1;
    AWREADY = 1'b0; WREADY = 1'b0; DM_write = 1'b0;
    checks++; if ({dbg_state, DM_stall, BREADY} !== {ST_DONE, 2'b01}) begin errors++;
      $display("FAIL post_done: got %b expected %b", {dbg_state, DM_stall, BREADY}, {ST_DONE, 2'b01}); end
    @(negedge clk);
    DM_WEB = 1'b1; DM_addr = 32'h0000_0054;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({dbg_state, DM_stall, ARVALID, BREADY} !== {ST_IDLE, 3'b101}) begin errors++;
        $display("FAIL post_blocked_%0d: got %b expected %b", k, {dbg_state, DM_stall, ARVALID, BREADY}, {ST_IDLE, 3'b101}); end
      @(negedge clk); #1;
    end
    BVALID = 1'b1; BRESP = 2'b00;
    @(negedge clk); #1;
    BVALID = 1'b0;
    checks++; if ({dbg_state, DM_stall, ARVALID, BREADY} !== {ST_IDLE, 3'b100}) begin errors++;
      $display("FAIL post_after_b: got %b expected %b", {dbg_state, DM_stall, ARVALID, BREADY}, {ST_IDLE, 3'b100}); end
    @(negedge clk); #1;
    checks++; if ({ARVALID, ARADDR} !== {1'b1, 32'h0000_0054}) begin errors++;
      $display("FAIL post_ar: got %h expected %h", {ARVALID, ARADDR}, {1'b1, 32'h0000_0054}); end
    ARREADY = 1'b1;
    @(negedge clk); #1;
    ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h7777_7777; RRESP = 2'b00;
    @(negedge clk); #1;
    RVALID = 1'b0;
    checks++; if ({dbg_state, DM_DO} !== {ST_DONE, 32'h7777_7777}) begin errors++;
      $display("FAIL post_read_done: got %h expected %h", {dbg_state, DM_DO}, {ST_DONE, 32'h7777_7777}); end
    idle(1);
  endtask
`endif

  initial begin
    test_reset();
    test_read();
`ifdef DM_POSTED_WRITE_EN
    test_posted();
`else
    test_write_backpressure();
`endif
    test_write();
    test_back_to_back();
    test_read_error();
    test_reset_mid();
    test_write_error();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
